// File: rtl/prog_counter_if.sv
// Control/status bundle for the programmable up/down counter.
interface prog_counter_if #(
  parameter int unsigned WIDTH = 8
);

  logic             ENABLE;
  logic             UP;
  logic             CLEAR;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic             MOD_WE;
  logic [WIDTH-1:0] MOD_IN;
  logic [WIDTH-1:0] COUNT;
  logic [WIDTH-1:0] TOP;
  logic             TC;
  logic             WRAP;
  logic             PEND;

  // Controller side: drives commands, observes counter state.
  modport master (
    output ENABLE, UP, CLEAR, LOAD, LOAD_VAL, MOD_WE, MOD_IN,
    input  COUNT, TOP, TC, WRAP, PEND
  );

  // Counter side.
  modport slave (
    input  ENABLE, UP, CLEAR, LOAD, LOAD_VAL, MOD_WE, MOD_IN,
    output COUNT, TOP, TC, WRAP, PEND
  );

endinterface

// File: rtl/prog_counter.sv
// Programmable-modulus up/down counter with deferred top update.
// A new top written via MOD_WE is held pending and only takes effect on
// CLEAR, LOAD or a wrap, so a running sequence is never cut short.
module prog_counter #(
  parameter int unsigned WIDTH    = 8,
  parameter bit          SATURATE = 1'b0
) (
  input logic           CLK,
  input logic           RST_n,
  prog_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_q,    count_d;
  logic [WIDTH-1:0] top_q,      top_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             pend_q,     pend_d;
  logic             wrap_q,     wrap_d;

  logic             terminal_c;
  logic [WIDTH-1:0] new_top_c;
  logic [WIDTH-1:0] load_clamp_c;

  // Terminal depends on direction; new top is the value an apply would use.
  always_comb begin
    terminal_c   = bus.UP ? (count_q == top_q) : (count_q == ZERO);
    new_top_c    = bus.MOD_WE ? bus.MOD_IN : (pend_q ? pend_val_q : top_q);
    load_clamp_c = (bus.LOAD_VAL > new_top_c) ? new_top_c : bus.LOAD_VAL;
  end

  // Next-state: CLEAR > LOAD > ENABLE > hold; MOD_WE always lands in pending.
  always_comb begin
    count_d    = count_q;
    top_d      = top_q;
    pend_val_d = bus.MOD_WE ? bus.MOD_IN : pend_val_q;
    pend_d     = pend_q | bus.MOD_WE;
    wrap_d     = 1'b0;

    if (bus.CLEAR) begin
      count_d = ZERO;
      top_d   = new_top_c;
      pend_d  = 1'b0;
    end else if (bus.LOAD) begin
      count_d = load_clamp_c;
      top_d   = new_top_c;
      pend_d  = 1'b0;
    end else if (bus.ENABLE) begin
      if (!terminal_c) begin
        count_d = bus.UP ? (count_q + ONE) : (count_q - ONE);
      end else if (!SATURATE) begin
        // Wrap: apply pending top; a down-count reloads from the new top.
        wrap_d  = 1'b1;
        top_d   = new_top_c;
        pend_d  = 1'b0;
        count_d = bus.UP ? ZERO : new_top_c;
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      count_q    <= ZERO;
      top_q      <= ONES;
      pend_val_q <= ONES;
      pend_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      top_q      <= top_d;
      pend_val_q <= pend_val_d;
      pend_q     <= pend_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.COUNT = count_q;
  assign bus.TOP   = top_q;
  assign bus.PEND  = pend_q;
  assign bus.WRAP  = wrap_q;
  // Terminal flag is combinational and suppressed while in reset.
  assign bus.TC    = RST_n & bus.ENABLE & ~bus.CLEAR & ~bus.LOAD & terminal_c;

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: wrap and saturating instances (WIDTH=4) share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_prog_counter;

  localparam int MAXV = 15;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b1;
  logic       en = 1'b0, up = 1'b0, clr = 1'b0, ld = 1'b0, mwe = 1'b0;
  logic [3:0] lv = 4'd0, mi = 4'd0;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state per instance: index 0 wraps, index 1 saturates.
  int m_cnt[2]  = '{0, 0};
  int m_top[2]  = '{MAXV, MAXV};
  int m_pval[2] = '{MAXV, MAXV};
  bit m_pend[2] = '{1'b0, 1'b0};
  bit m_wrap[2] = '{1'b0, 1'b0};

  prog_counter_if #(.WIDTH(4)) if0 ();
  prog_counter_if #(.WIDTH(4)) if1 ();

  assign if0.ENABLE = en;  assign if1.ENABLE = en;
  assign if0.UP = up;      assign if1.UP = up;
  assign if0.CLEAR = clr;  assign if1.CLEAR = clr;
  assign if0.LOAD = ld;    assign if1.LOAD = ld;
  assign if0.LOAD_VAL = lv; assign if1.LOAD_VAL = lv;
  assign if0.MOD_WE = mwe; assign if1.MOD_WE = mwe;
  assign if0.MOD_IN = mi;  assign if1.MOD_IN = mi;

  prog_counter #(.WIDTH(4), .SATURATE(1'b0)) dut0 (.CLK(CLK), .RST_n(RST_n), .bus(if0));
  prog_counter #(.WIDTH(4), .SATURATE(1'b1)) dut1 (.CLK(CLK), .RST_n(RST_n), .bus(if1));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural rules: pending top is applied on clear/load/wrap; saturate holds.
  task automatic model_step();
    int nt;
    bit at_term;
    for (int k = 0; k < 2; k++) begin
      if (!RST_n) begin
        m_cnt[k] = 0; m_top[k] = MAXV; m_pval[k] = MAXV; m_pend[k] = 0; m_wrap[k] = 0;
      end else begin
        nt = mwe ? int'(mi) : (m_pend[k] ? m_pval[k] : m_top[k]);
        at_term = up ? (m_cnt[k] == m_top[k]) : (m_cnt[k] == 0);
        m_wrap[k] = 0;
        if (mwe) m_pval[k] = int'(mi);
        if (clr) begin
          m_cnt[k] = 0; m_top[k] = nt; m_pend[k] = 0;
        end else if (ld) begin
          m_top[k] = nt; m_cnt[k] = (int'(lv) < nt) ? int'(lv) : nt; m_pend[k] = 0;
        end else begin
          if (mwe) m_pend[k] = 1;
          if (en) begin
            if (!at_term) m_cnt[k] = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
            else if (k == 0) begin
              m_wrap[k] = 1; m_top[k] = nt; m_pend[k] = 0;
              m_cnt[k] = up ? 0 : nt;
            end
          end
        end
      end
    end
  endtask

  always @(posedge CLK or negedge RST_n) model_step();

  task automatic cmp(input int k, input int c, input int t, input int p, input int w, input int tc);
    int exp_tc;
    exp_tc = (RST_n && en && !clr && !ld &&
              (up ? (m_cnt[k] == m_top[k]) : (m_cnt[k] == 0))) ? 1 : 0;
    chk($sformatf("s%0d.COUNT", k), c, m_cnt[k]);
    chk($sformatf("s%0d.TOP", k), t, m_top[k]);
    chk($sformatf("s%0d.PEND", k), p, int'(m_pend[k]));
    chk($sformatf("s%0d.WRAP", k), w, int'(m_wrap[k]));
    chk($sformatf("s%0d.TC", k), tc, exp_tc);
  endtask

  // Per-cycle compare, one time unit after inputs change, away from both edges.
  always @(negedge CLK) begin
    #1;
    cmp(0, int'(if0.COUNT), int'(if0.TOP), int'(if0.PEND), int'(if0.WRAP), int'(if0.TC));
    cmp(1, int'(if1.COUNT), int'(if1.TOP), int'(if1.PEND), int'(if1.WRAP), int'(if1.TC));
  end

  initial begin
    en = 1'b1; up = 1'b1;
    #2 RST_n = 1'b0;
    @(negedge CLK); #2;
    chk("rst.COUNT", int'(if0.COUNT), 0);
    chk("rst.TOP", int'(if0.TOP), 15);
    chk("rst.PEND", int'(if0.PEND), 0);
    chk("rst.WRAP", int'(if0.WRAP), 0);
    chk("rst.TC", int'(if0.TC), 0);
    #1 RST_n = 1'b1;
    #1;
    chk("run.COUNT0", int'(if0.COUNT), 0);

    // Free run 0..15,0 on the wrap instance; saturating one sticks at 15.
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK); #2;
      chk("run.COUNT", int'(if0.COUNT), i % 16);
      chk("run.TC", int'(if0.TC), (i == 15) ? 1 : 0);
      chk("run.WRAP", int'(if0.WRAP), (i == 16) ? 1 : 0);
      chk("sat.WRAP", int'(if1.WRAP), 0);
    end
    chk("sat.COUNT", int'(if1.COUNT), 15);
    chk("sat.TC", int'(if1.TC), 1);

    // Deferred top: write 9 at count 5, applied only at the wrap.
    @(negedge CLK); clr = 1'b1; en = 1'b0;
    @(negedge CLK); clr = 1'b0; en = 1'b1; up = 1'b1; #2;
    chk("pend.COUNT0", int'(if0.COUNT), 0);
    repeat (5) @(negedge CLK);
    mwe = 1'b1; mi = 4'd9; #2;
    chk("pend.COUNT5", int'(if0.COUNT), 5);
    @(negedge CLK); mwe = 1'b0; #2;
    chk("pend.PEND", int'(if0.PEND), 1);
    chk("pend.TOPold", int'(if0.TOP), 15);
    repeat (9) @(negedge CLK); #2;
    chk("pend.COUNT15", int'(if0.COUNT), 15);
    @(negedge CLK); #2;
    chk("pend.TOPnew", int'(if0.TOP), 9);
    chk("pend.PEND0", int'(if0.PEND), 0);
    chk("pend.WRAP", int'(if0.WRAP), 1);
    chk("sat.PENDheld", int'(if1.PEND), 1);
    chk("sat.TOPheld", int'(if1.TOP), 15);
    repeat (9) @(negedge CLK); #2;
    chk("pend.COUNT9", int'(if0.COUNT), 9);
    chk("pend.TC9", int'(if0.TC), 1);
    @(negedge CLK); #2;
    chk("pend.COUNTwrap", int'(if0.COUNT), 0);

    // Down-count from 0 with pending top 6 reloads to 6.
    en = 1'b0; mwe = 1'b1; mi = 4'd6;
    @(negedge CLK); mwe = 1'b0; en = 1'b1; up = 1'b0; #2;
    chk("down.TC", int'(if0.TC), 1);
    @(negedge CLK); #2;
    chk("down.COUNT", int'(if0.COUNT), 6);
    chk("down.TOP", int'(if0.TOP), 6);
    chk("down.WRAP", int'(if0.WRAP), 1);

    // Clear with coincident top write, then clamped load, then clear over load.
    clr = 1'b1; mwe = 1'b1; mi = 4'd9; en = 1'b0; up = 1'b1;
    @(negedge CLK); clr = 1'b0; mwe = 1'b0; ld = 1'b1; lv = 4'd12; en = 1'b1; up = 1'b0; #2;
    chk("load.TOP9", int'(if0.TOP), 9);
    chk("load.TCgated", int'(if0.TC), 0);
    @(negedge CLK); clr = 1'b1; ld = 1'b1; mwe = 1'b1; mi = 4'd3; #2;
    chk("load.COUNT", int'(if0.COUNT), 9);
    @(negedge CLK); clr = 1'b1; ld = 1'b0; mwe = 1'b1; mi = 4'd0; en = 1'b0; #2;
    chk("clr.COUNT", int'(if0.COUNT), 0);
    chk("clr.TOP3", int'(if0.TOP), 3);

    // Top of zero: TC follows ENABLE.
    @(negedge CLK); clr = 1'b0; mwe = 1'b0; en = 1'b1; up = 1'b1; #2;
    chk("zero.TOP", int'(if0.TOP), 0);
    chk("zero.TC", int'(if0.TC), 1);
    @(negedge CLK); en = 1'b0; #2;
    chk("zero.COUNT", int'(if0.COUNT), 0);
    chk("zero.TCoff", int'(if0.TC), 0);

    // Asynchronous reset between edges with count 7 and a pending top.
    @(negedge CLK); clr = 1'b1; mwe = 1'b1; mi = 4'd15;
    @(negedge CLK); clr = 1'b0; mwe = 1'b0; ld = 1'b1; lv = 4'd7;
    @(negedge CLK); ld = 1'b0; mwe = 1'b1; mi = 4'd4;
    @(negedge CLK); mwe = 1'b0; en = 1'b1; up = 1'b1; #2;
    chk("arst.COUNT7", int'(if0.COUNT), 7);
    chk("arst.PEND1", int'(if0.PEND), 1);
    RST_n = 1'b0; #1;
    chk("arst.COUNT", int'(if0.COUNT), 0);
    chk("arst.TOP", int'(if0.TOP), 15);
    chk("arst.PEND", int'(if0.PEND), 0);
    chk("arst.TC", int'(if0.TC), 0);
    chk("arst.s1COUNT", int'(if1.COUNT), 0);
    #1 RST_n = 1'b1;
    @(negedge CLK); #2;
    chk("arst.first", int'(if0.COUNT), 1);

    // Randomized traffic; the compare process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      @(negedge CLK);
      en  = ($urandom_range(0, 99) < 80);
      if ($urandom_range(0, 19) == 0) up = ~up;
      clr = ($urandom_range(0, 99) < 3);
      ld  = ($urandom_range(0, 99) < 5);
      lv  = 4'($urandom_range(0, 15));
      mwe = ($urandom_range(0, 99) < 8);
      mi  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        #2 RST_n = 1'b0;
        #2 RST_n = 1'b1;
      end
    end
    @(negedge CLK); #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: count, load and modulus width, range 1..32.
REQ-002 The block SHALL have parameter SATURATE, default 0: 0 means wrap at terminal, 1 means hold at terminal.
REQ-003 The block SHALL have port CLK, input, 1: single clock, rising-edge active.
REQ-004 The block SHALL have port RST_n, input, 1: asynchronous active-low reset.
REQ-005 The block SHALL have port ENABLE, input, 1: count-step qualifier.
REQ-006 The block SHALL have port UP, input, 1: direction, 1 = increment, 0 = decrement.
REQ-007 The block SHALL have port CLEAR, input, 1: synchronous clear.
REQ-008 The block SHALL have port LOAD, input, 1: synchronous parallel load.
REQ-009 The block SHALL have port LOAD_VAL, input, WIDTH: value to load.
REQ-010 The block SHALL have port MOD_WE, input, 1: write strobe for the pending top value.
REQ-011 The block SHALL have port MOD_IN, input, WIDTH: new top value (modulus minus 1).
REQ-012 The block SHALL have port COUNT, output, WIDTH: registered count.
REQ-013 The block SHALL have port TOP, output, WIDTH: registered active top value.
REQ-014 The block SHALL have port TC, output, 1: combinational terminal-count flag.
REQ-015 The block SHALL have port WRAP, output, 1: registered one-cycle pulse following a wrap.
REQ-016 The block SHALL have port PEND, output, 1: registered flag, high while a pending top is waiting to be applied.

Function
REQ-017 The terminal condition SHALL be COUNT==TOP when UP=1, and COUNT==0 when UP=0.
REQ-018 Priority per rising edge SHALL be CLEAR > LOAD > ENABLE, then hold.
REQ-019 On CLEAR, COUNT SHALL become 0, and any pending top SHALL be applied to TOP (PEND cleared).
REQ-020 On LOAD, any pending top SHALL be applied first, then COUNT SHALL take min(LOAD_VAL, new TOP).
REQ-021 On ENABLE with UP=1 and no terminal, COUNT SHALL increment by 1; with UP=0 and no terminal, COUNT SHALL decrement by 1.
REQ-022 On ENABLE at terminal with SATURATE=0 (wrap event), COUNT SHALL go to 0 (UP=1) or to the effective TOP (UP=0).
REQ-023 On a wrap event, any pending top SHALL be applied in the same edge; with UP=0, the new top SHALL be the reload value.
REQ-024 On ENABLE at terminal with SATURATE=1, COUNT SHALL hold, no wrap event SHALL occur, and the pending top SHALL remain pending.
REQ-025 TC SHALL equal terminal AND ENABLE AND NOT CLEAR AND NOT LOAD, combinationally, in both SATURATE modes.
REQ-026 WRAP SHALL be high for exactly the one cycle after each wrap event, and SHALL never assert when SATURATE=1.
REQ-027 MOD_WE SHALL write MOD_IN to the pending register and set PEND; a later MOD_WE before application SHALL overwrite it (last write wins).
REQ-028 MOD_WE coincident with CLEAR, LOAD or a wrap SHALL apply the MOD_IN value of that same cycle.
REQ-029 TOP=0 SHALL be legal: COUNT stays 0, and TC equals ENABLE (gated per REQ-025) every cycle.
REQ-030 Changing UP mid-count SHALL take effect on the next enabled edge without glitching COUNT.
REQ-031 COUNT SHALL never exceed TOP; all arithmetic SHALL be WIDTH-bit with no carry out.
REQ-032 ENABLE=0 with no CLEAR or LOAD SHALL hold COUNT, TOP and PEND, while MOD_WE still writes the pending register.

Reset
REQ-033 RST_n low SHALL asynchronously force COUNT=0, TOP=all ones, the pending register to all ones, PEND=0 and WRAP=0.
REQ-034 TC SHALL be 0 during reset; reset asserted mid-count or with a pending top SHALL discard all state.
REQ-035 After RST_n deasserts, the first enabled edge SHALL increment from 0 with UP=1.

Verification
REQ-036 WIDTH=4, reset, then ENABLE=1 and UP=1 for 17 cycles -> COUNT runs 0..15,0; TC high only at COUNT=15; WRAP high the cycle COUNT=0.
REQ-037 With COUNT=5, MOD_WE and MOD_IN=9 -> PEND=1 and TOP remains 15 until the wrap at 15; then TOP=9 and PEND=0, and the next sequence runs 0..9.
REQ-038 UP=0 from COUNT=0 with pending top 6 -> COUNT becomes 6, TOP=6, WRAP pulses.
REQ-039 SATURATE=1, UP=1, TOP=15 -> COUNT holds at 15, TC stays high while ENABLE=1, WRAP never asserts.
REQ-040 With TOP=9, LOAD_VAL=12 and LOAD together with ENABLE -> COUNT=9, no TC; CLEAR together with LOAD and MOD_WE=3 -> COUNT=0, TOP=3.
REQ-041 RST_n pulsed low between clock edges with COUNT=7 and PEND=1 -> COUNT=0, TOP=all ones and PEND=0 immediately, without waiting for a clock edge.
